// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product,
// one bit-pair retired per cycle, start/busy/done handshake.
module booth_seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned Iters = WIDTH / 2;
    localparam int unsigned CntW  = $clog2(Iters + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(Iters - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [WIDTH+1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mq_q, mq_d;
    logic              prev_q, prev_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic [WIDTH+1:0]   mext;
    logic [WIDTH+1:0]   addend;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH+1:0] shifted;
    logic [WIDTH+1:0]   acc_next;
    logic [WIDTH-1:0]   mq_next;

    // One Booth step: recode {q[1], q[0], q[-1]}, add, then arithmetic shift of {acc, mq} by 2.
    always_comb begin
        mext   = {{2{mcand_q[WIDTH-1]}}, mcand_q};
        addend = '0;
        unique case ({mq_q[1:0], prev_q})
            3'b001, 3'b010: addend = mext;
            3'b011:         addend = mext << 1;
            3'b100:         addend = -(mext << 1);
            3'b101, 3'b110: addend = -mext;
            default:        addend = '0;
        endcase
        sum      = acc_q + addend;
        shifted  = {{2{sum[WIDTH+1]}}, sum, mq_q[WIDTH-1:2]};
        acc_next = shifted[2*WIDTH+1:WIDTH];
        mq_next  = shifted[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mq_d    = mq_q;
        prev_d  = prev_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCalc;
                    mcand_d = M;
                    mq_d    = Q;
                    acc_d   = '0;
                    prev_d  = 1'b0;
                    count_d = '0;
                    busy_d  = 1'b1;
                end
            end
            StCalc: begin
                acc_d   = acc_next;
                mq_d    = mq_next;
                prev_d  = mq_q[1];
                count_d = count_q + 1'b1;
                if (count_q == LastCnt) begin
                    // Product registers change only here, so partial sums are never visible.
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = acc_next[WIDTH-1:0];
                    lo_d    = mq_next;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= StIdle;
            count_q <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mq_q    <= '0;
            prev_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mq_q    <= mq_d;
            prev_q  <= prev_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: cycle-level behavioural model plus directed vectors
// with hand-computed products.
module tb_booth_seq_multiplier;
    logic        clk;
    logic        clear;
    logic        start;
    logic [31:0] m_in;
    logic [31:0] q_in;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    bit mon_en = 0;

    booth_seq_multiplier #(.WIDTH(32)) dut (
        .clock(clk),
        .clear(clear),
        .start(start),
        .M(m_in),
        .Q(q_in),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: accepted request -> 16 busy cycles -> one done cycle carrying the signed product.
    logic        m_busy = 0;
    logic        m_done = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [63:0] pend;
    int          left = 0;

    always @(posedge clk) begin
        if (!clear) begin
            m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; left = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            left--;
            if (left == 0) begin
                m_busy = 0;
                m_done = 1;
                m_hi   = pend[63:32];
                m_lo   = pend[31:0];
            end
        end else if (start) begin
            m_busy = 1;
            left   = 16;
            pend   = longint'($signed(m_in)) * longint'($signed(q_in));
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_busy", 64'(busy), 64'(m_busy));
            chk("mon_done", 64'(done), 64'(m_done));
            chk("mon_hi", 64'(hi), 64'(m_hi));
            chk("mon_lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic run_op(input logic [31:0] m, input logic [31:0] q, input logic [31:0] eh,
                          input logic [31:0] el, input bit inject, input string name);
        int n;
        int nb;
        @(negedge clk);
        m_in = m; q_in = q; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        nb = busy ? 1 : 0;
        while (!done && n < 40) begin
            if (inject && n == 5) begin
                start = 1'b1; m_in = 32'd9; q_in = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (busy) nb++;
        end
        start = 1'b0;
        chk({name, "_latency"}, 64'(n), 64'd17);
        chk({name, "_busy_cycles"}, 64'(nb), 64'd16);
        chk({name, "_hi"}, 64'(hi), 64'(eh));
        chk({name, "_lo"}, 64'(lo), 64'(el));
        chk({name, "_model"}, {m_hi, m_lo}, {eh, el});
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int nd;
        clear = 1'b0; start = 1'b0; m_in = '0; q_in = '0;
        repeat (2) @(negedge clk);
        mon_en = 1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        clear = 1'b1;
        @(negedge clk);

        run_op(32'd5, 32'd4, 32'h0, 32'h14, 0, "5x4");
        run_op(-32'sd7, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, "m7x3");
        run_op(32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0, "minxmin");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 0, "m1xm1");
        run_op(32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 0, "maxxmin");
        run_op(32'h0, 32'h12345678, 32'h0, 32'h0, 0, "zero");
        run_op(32'd6, 32'd7, 32'h0, 32'h2A, 1, "restart_ignored");

        // Abort mid-calculation with clear.
        @(negedge clk);
        m_in = 32'd6; q_in = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_hilo", {hi, lo}, 64'd0);
        clear = 1'b1;
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_clear", 64'(nd), 64'd0);
        run_op(32'd3, 32'd3, 32'h0, 32'h9, 0, "3x3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
